// File: rtl/lms_filter_mc.sv
// Multichannel time-multiplexed adaptive LMS FIR: one serial MAC walks the taps of the
// accepted channel, registers y and e, then optionally updates that channel's coefficients.
module lms_filter_mc #(
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int TAPS = 16,
    parameter int N_CH = 2,
    localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           valid_u_in,
    input  logic           valid_d_in,
    output logic           ready_out,
    input  logic [CHW-1:0] ch_in,
    input  logic [DW-1:0]  u_in,
    input  logic [DW-1:0]  d_in,
    input  logic           mode,
    input  logic [DW-1:0]  mu_in,
    input  logic           mu_we,
    input  logic [CHW-1:0] ch_mu,
    input  logic           coef_clr,
    output logic           valid_out,
    output logic [CHW-1:0] ch_out,
    output logic [DW-1:0]  out,
    output logic [DW-1:0]  err
);
    localparam int KW  = $clog2(TAPS);
    localparam int PW  = DW + CW;
    localparam int AW  = DW + CW + KW;
    localparam int GW  = DW + 1;
    localparam int DUW = DW + 2;
    localparam int SW  = ((CW > DUW) ? CW : DUW) + 1;

    typedef enum logic [1:0] {IDLE, FILT, OUT, UPD} state_t;

    state_t                state_q;
    logic signed [DW-1:0]  x_q [N_CH][TAPS];
    logic signed [CW-1:0]  w_q [N_CH][TAPS];
    logic        [DW-1:0]  mu_q [N_CH];
    logic signed [DW-1:0]  d_q;
    logic        [CHW-1:0] ch_q;
    logic                  mode_q;
    logic        [DW-1:0]  mu_lat_q;
    logic        [KW-1:0]  k_q;
    logic signed [AW-1:0]  acc_q;
    logic signed [GW-1:0]  g_q;
    logic                  valid_out_q;
    logic        [CHW-1:0] ch_out_q;
    logic        [DW-1:0]  out_q;
    logic        [DW-1:0]  err_q;

    logic signed [DW-1:0]  x_sel;
    logic signed [CW-1:0]  w_sel;
    logic signed [AW-1:0]  acc_d;
    logic signed [AW-1:0]  y_wide;
    logic signed [DW-1:0]  y_sat;
    logic signed [DW:0]    e_wide;
    logic signed [DW-1:0]  e_sat;
    logic signed [DW:0]    mu_s;
    logic signed [GW-1:0]  g_d;
    logic signed [DUW-1:0] du_d;
    logic signed [SW-1:0]  w_sum;
    logic signed [CW-1:0]  w_d;
    logic                  ch_in_ok;
    logic                  ch_mu_ok;
    logic                  accept;
    logic                  last_k;

    // Handshake: a sample is taken on a rising edge where valid_u_in, valid_d_in and ready_out
    // are all high and ch_in names a real channel; ready_out is high only in IDLE without coef_clr.
    assign ch_in_ok  = 32'(ch_in) < 32'(N_CH);
    assign ch_mu_ok  = 32'(ch_mu) < 32'(N_CH);
    assign ready_out = nrst && (state_q == IDLE) && !coef_clr;
    assign accept    = valid_u_in && valid_d_in && ready_out && ch_in_ok;
    assign last_k    = (k_q == KW'(TAPS - 1));

    assign x_sel  = x_q[ch_q][k_q];
    assign w_sel  = w_q[ch_q][k_q];
    assign acc_d  = acc_q + AW'(PW'(w_sel) * PW'(x_sel));
    assign y_wide = acc_q >>> (CW - 1);
    assign y_sat  = (y_wide[AW-1:DW-1] == {(AW-DW+1){y_wide[AW-1]}}) ? y_wide[DW-1:0]
                  : {y_wide[AW-1], {(DW-1){~y_wide[AW-1]}}};
    assign e_wide = (DW+1)'(d_q) - (DW+1)'(y_sat);
    assign e_sat  = (e_wide[DW] == e_wide[DW-1]) ? e_wide[DW-1:0]
                  : {e_wide[DW], {(DW-1){~e_wide[DW]}}};

    // mu is an unsigned magnitude, so it gets a zero sign bit before the signed multiply.
    assign mu_s  = {1'b0, mu_lat_q};
    assign g_d   = GW'(((2*DW)'(mu_s) * (2*DW)'(e_sat)) >>> (DW - 1));
    assign du_d  = DUW'(((2*DW+1)'(g_q) * (2*DW+1)'(x_sel)) >>> (DW - 1));
    assign w_sum = SW'(w_sel) + SW'(du_d);
    assign w_d   = (w_sum[SW-1:CW-1] == {(SW-CW+1){w_sum[SW-1]}}) ? w_sum[CW-1:0]
                 : {w_sum[SW-1], {(CW-1){~w_sum[SW-1]}}};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            d_q         <= '0;
            ch_q        <= '0;
            mode_q      <= 1'b0;
            mu_lat_q    <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            g_q         <= '0;
            valid_out_q <= 1'b0;
            ch_out_q    <= '0;
            out_q       <= '0;
            err_q       <= '0;
            for (int c = 0; c < N_CH; c++) begin
                mu_q[c] <= '0;
                for (int k = 0; k < TAPS; k++) begin
                    x_q[c][k] <= '0;
                    w_q[c][k] <= '0;
                end
            end
        end else begin
            valid_out_q <= 1'b0;
            if (mu_we && ch_mu_ok) mu_q[ch_mu] <= mu_in;
            case (state_q)
                IDLE: begin
                    if (coef_clr) begin
                        if (ch_in_ok) begin
                            for (int k = 0; k < TAPS; k++) w_q[ch_in][k] <= '0;
                        end
                    end else if (accept) begin
                        for (int k = TAPS - 1; k > 0; k--) x_q[ch_in][k] <= x_q[ch_in][k-1];
                        x_q[ch_in][0] <= u_in;
                        d_q      <= d_in;
                        ch_q     <= ch_in;
                        mode_q   <= mode;
                        mu_lat_q <= mu_q[ch_in];
                        acc_q    <= '0;
                        k_q      <= '0;
                        state_q  <= FILT;
                    end
                end
                FILT: begin
                    acc_q <= acc_d;
                    k_q   <= k_q + KW'(1);
                    if (last_k) state_q <= OUT;
                end
                OUT: begin
                    out_q       <= y_sat;
                    err_q       <= e_sat;
                    ch_out_q    <= ch_q;
                    valid_out_q <= 1'b1;
                    g_q         <= g_d;
                    k_q         <= '0;
                    state_q     <= mode_q ? IDLE : UPD;
                end
                UPD: begin
                    w_q[ch_q][k_q] <= w_d;
                    k_q            <= k_q + KW'(1);
                    if (last_k) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign valid_out = valid_out_q;
    assign ch_out    = ch_out_q;
    assign out       = out_q;
    assign err       = err_q;
endmodule
